// File: rtl/mem_pkg.sv
// Shared widths, state encoding and address map defaults
// for the SRAM-backed data memory stage.
package mem_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;
  localparam int WIDX_W  = SRAM_AW - 1;

  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/mem_sram_ctrl_if.sv
// SRAM-side bus: half-word address, split data in/out,
// output enable and active-low write strobe.
interface mem_sram_ctrl_if;
  import mem_pkg::*;

  logic [SRAM_AW-1:0] addr;
  logic [SRAM_DW-1:0] dq_out;
  logic [SRAM_DW-1:0] dq_in;
  logic               dq_oe;
  logic               we_n;

  modport master (
    output addr, dq_out, dq_oe, we_n,
    input  dq_in
  );

  modport slave (
    input  addr, dq_out, dq_oe, we_n,
    output dq_in
  );

endinterface

// File: rtl/mem_read_buf.sv
// One-entry read buffer: word index, data and valid bit,
// filled by completed reads and kept coherent with writes.
module mem_read_buf
  import mem_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDX_W-1:0] lk_idx_i,
  output logic              hit_o,
  output logic [31:0]       data_o,
  input  logic              fill_i,
  input  logic              wr_i,
  input  logic [WIDX_W-1:0] idx_i,
  input  logic [31:0]       data_i
);

  logic              valid_q, valid_d;
  logic [WIDX_W-1:0] idx_q, idx_d;
  logic [31:0]       data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    data_d  = data_q;
    if (fill_i) begin
      valid_d = 1'b1;
      idx_d   = idx_i;
      data_d  = data_i;
    end else if (wr_i && valid_q && idx_i == idx_q) begin
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign hit_o  = valid_q && (lk_idx_i == idx_q);
  assign data_o = data_q;

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM stage controller: 32-bit load/store over a 16-bit SRAM
// in two halves. Define MEM_READ_BUFFER_EN for a read buffer.
module mem_sram_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        Address,
  input  logic [31:0]        Write_Data,
  output logic [31:0]        Read_Data,
  output logic               Ready,
  output logic               Freeze,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [SRAM_DW-1:0] SRAM_DQ_Out,
  input  logic [SRAM_DW-1:0] SRAM_DQ_In,
  output logic               SRAM_DQ_OE,
  output logic               SRAM_WE_N
);

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [WIDX_W-1:0] idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [15:0]       lo_q, lo_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [WIDX_W-1:0] idx_in;
  logic              req;
  logic              last;
  logic              act;
  logic              we;

  assign idx_in = WIDX_W'((Address - BASE_ADDR) >> 2);
  assign req    = MEM_R_EN | MEM_W_EN;
  assign last   = (cnt_q == CNT_LAST);

`ifdef MEM_READ_BUFFER_EN
  logic        hit;
  logic [31:0] hit_data;
  logic        fin;

  assign fin = (state_q == S_HIGH) && last;

  mem_read_buf u_buf (
    .clk_i    (CLK),
    .rst_i    (RST),
    .lk_idx_i (idx_in),
    .hit_o    (hit),
    .data_o   (hit_data),
    .fill_i   (fin && !wr_q),
    .wr_i     (fin && wr_q),
    .idx_i    (idx_q),
    .data_i   (wr_q ? wdata_q : {SRAM_DQ_In, lo_q})
  );
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = idx_in;
          wdata_d = Write_Data;
          wr_d    = MEM_W_EN;
          cnt_d   = '0;
          state_d = S_LOW;
`ifdef MEM_READ_BUFFER_EN
          if (!MEM_W_EN && hit) begin
            state_d = S_DONE;
            rdata_d = hit_data;
          end
`endif
        end
      end
      S_LOW: begin
        if (last) begin
          cnt_d   = '0;
          lo_d    = SRAM_DQ_In;
          state_d = S_HIGH;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      S_HIGH: begin
        if (last) begin
          cnt_d   = '0;
          state_d = S_DONE;
          if (!wr_q) rdata_d = {SRAM_DQ_In, lo_q};
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus outputs decode straight from registered state
  assign act = (state_q == S_LOW) || (state_q == S_HIGH);
  assign we  = act && wr_q;

  assign SRAM_ADDR   = act ? {idx_q, state_q == S_HIGH} : '0;
  assign SRAM_DQ_Out = !we ? '0 :
                       (state_q == S_HIGH) ? wdata_q[31:16] : wdata_q[15:0];
  assign SRAM_DQ_OE  = we;
  assign SRAM_WE_N   = ~we;

  assign Read_Data = rdata_q;
  assign Ready     = (state_q == S_DONE);
  assign Freeze    = req & ~Ready;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Randomized bench for mem_sram_ctrl against a word-level
// memory model, plus directed scenarios with literal checks.
module tb_mem_sram_ctrl;

  localparam int          WC   = 2;
  localparam logic [31:0] BASE = 32'd1024;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] Address, Write_Data, Read_Data;
  logic        Ready, Freeze;

  mem_sram_ctrl_if sif();

  mem_sram_ctrl #(.WAIT_CYCLES(WC), .BASE_ADDR(BASE)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .MEM_R_EN    (MEM_R_EN),
    .MEM_W_EN    (MEM_W_EN),
    .Address     (Address),
    .Write_Data  (Write_Data),
    .Read_Data   (Read_Data),
    .Ready       (Ready),
    .Freeze      (Freeze),
    .SRAM_ADDR   (sif.addr),
    .SRAM_DQ_Out (sif.dq_out),
    .SRAM_DQ_In  (sif.dq_in),
    .SRAM_DQ_OE  (sif.dq_oe),
    .SRAM_WE_N   (sif.we_n)
  );

  always #5 CLK = ~CLK;

  // SRAM array: async read, write on rising edge while strobed
  bit [15:0]   sram [0:(1<<18)-1];
  logic        pl_en = 1'b0;
  assign sif.dq_in = sram[sif.addr];

  always @(posedge CLK) begin
    if (!sif.we_n) sram[sif.addr] <= sif.dq_out;
    if (pl_en) begin
      sram[2] <= 16'h1234;
      sram[3] <= 16'hABCD;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int we_lo = 0;

  logic [31:0] ref_mem [int];
`ifdef MEM_READ_BUFFER_EN
  bit          bvalid = 1'b0;
  logic [16:0] bidx   = '0;
`endif

  bit          chk_en = 1'b0;
  logic        exp_ready, exp_freeze, exp_we;
  logic [17:0] exp_addr;
  logic [15:0] exp_dq;
  logic [31:0] exp_rdata;

  task automatic cmp(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", n, $time, a, e);
    end
  endtask

  always @(negedge CLK) begin
    if (!sif.we_n) we_lo++;
    if (chk_en) begin
      cmp("ready",  32'(Ready),      32'(exp_ready));
      cmp("freeze", 32'(Freeze),     32'(exp_freeze));
      cmp("we_n",   32'(sif.we_n),   32'(!exp_we));
      cmp("dq_oe",  32'(sif.dq_oe),  32'(exp_we));
      cmp("addr",   32'(sif.addr),   32'(exp_addr));
      cmp("rdata",  Read_Data,       exp_rdata);
      if (exp_we) cmp("dq_out", 32'(sif.dq_out), 32'(exp_dq));
    end
  end

  function automatic logic [16:0] widx(input logic [31:0] a);
    logic [31:0] d;
    d = (a - BASE) / 4;
    return d[16:0];
  endfunction

  function automatic logic [31:0] ref_rd(input logic [16:0] i);
    return ref_mem.exists(int'(i)) ? ref_mem[int'(i)] : 32'h0;
  endfunction

  task automatic set_exp(input logic r, input logic f, input logic w,
                         input logic [17:0] a, input logic [15:0] d);
    exp_ready  = r;
    exp_freeze = f;
    exp_we     = w;
    exp_addr   = a;
    exp_dq     = d;
  endtask

  task automatic idle(input int n);
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    Address  = $urandom;
    set_exp(0, 0, 0, '0, '0);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic access(input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
    logic [16:0] i;
    bit          hit;
    int          lat;
    bit          half;
    i   = widx(a);
    hit = 1'b0;
`ifdef MEM_READ_BUFFER_EN
    hit = !wr && bvalid && (bidx == i);
`endif
    lat = hit ? 1 : 2 * WC + 1;
    for (int k = 0; k <= lat; k++) begin
      if (k == 0) begin
        MEM_R_EN   = rd;
        MEM_W_EN   = wr;
        Address    = a;
        Write_Data = d;
      end else begin
        Address    = $urandom;
        Write_Data = $urandom;
      end
      half = (k > WC);
      if (!hit && k >= 1 && k <= 2 * WC)
        set_exp(0, 1, wr, {i, half}, half ? d[31:16] : d[15:0]);
      else
        set_exp(k == lat, k != lat, 0, '0, '0);
      if (k == lat && !wr) exp_rdata = ref_rd(i);
      @(posedge CLK); #1;
    end
    if (wr) ref_mem[int'(i)] = d;
`ifdef MEM_READ_BUFFER_EN
    else begin
      bvalid = 1'b1;
      bidx   = i;
    end
`endif
  endtask

  task automatic reset_mid_write(input logic [31:0] a,
                                 input logic [31:0] d);
    logic [16:0] i;
    logic [31:0] w;
    i = widx(a);
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b1;
    Address = a;
    Write_Data = d;
    set_exp(0, 1, 0, '0, '0);
    @(posedge CLK); #1;
    set_exp(0, 1, 1, {i, 1'b0}, d[15:0]);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    set_exp(0, 1, 0, '0, '0);
    exp_rdata = '0;
    @(posedge CLK); #1;
    RST = 1'b0;
    idle(1);
    w = ref_rd(i);
    ref_mem[int'(i)] = {w[31:16], d[15:0]};
`ifdef MEM_READ_BUFFER_EN
    bvalid = 1'b0;
`endif
  endtask

  initial begin
    int w0;
    RST = 1'b1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    Address = '0;
    Write_Data = '0;
    exp_rdata = '0;
    set_exp(0, 0, 0, '0, '0);
    pl_en = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    pl_en = 1'b0;
    ref_mem[1] = 32'hABCD1234;
    chk_en = 1'b1;
    @(posedge CLK); #1;
    cmp("rst_dq_out", 32'(sif.dq_out), 32'h0);
    RST = 1'b0;
    idle(1);

    w0 = we_lo;
    access(0, 1, 32'd1024, 32'hDEADBEEF);
    cmp("wr_lo_half", 32'(sram[0]), 32'h0000BEEF);
    cmp("wr_hi_half", 32'(sram[1]), 32'h0000DEAD);
    cmp("we_n_cycles", 32'(we_lo - w0), 32'd4);
    idle(1);

    access(1, 0, 32'd1028, 32'h0);
    cmp("rd_value", Read_Data, 32'hABCD1234);
    idle(3);
    cmp("rd_held", Read_Data, 32'hABCD1234);

    access(1, 1, 32'd1032, 32'h00000055);
    cmp("both_rdata", Read_Data, 32'hABCD1234);
    cmp("both_lo", 32'(sram[4]), 32'h00000055);
    cmp("both_hi", 32'(sram[5]), 32'h0);
    idle(1);

`ifdef MEM_READ_BUFFER_EN
    access(1, 0, 32'd1028, 32'h0);
    cmp("buf_hit", Read_Data, 32'hABCD1234);
    access(0, 1, 32'd1028, 32'h00000077);
    access(1, 0, 32'd1028, 32'h0);
    cmp("buf_wr_upd", Read_Data, 32'h00000077);
    idle(1);
`endif

    reset_mid_write(32'd1036, 32'h5A5AC3C3);
    cmp("rst_abort_lo", 32'(sram[6]), 32'h0000C3C3);
    cmp("rst_abort_hi", 32'(sram[7]), 32'h0);

    for (int t = 0; t < 200; t++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 9) == 0)
        a = BASE - 32'($urandom_range(1, 12));
      else
        a = BASE + 32'($urandom_range(0, 47));
      if (kind < 5)
        access(1, 0, a, $urandom);
      else if (kind < 9)
        access(0, 1, a, $urandom);
      else
        access(1, 1, a, $urandom);
      idle($urandom_range(0, 2));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
